// File: rtl/guess_entry_ctrl.sv
// rtl/guess_entry_ctrl.sv - keypad debounce and 4-digit guess entry controller
//
// Purpose: synchronizes and debounces the keypad key_down level, turns each
// debounced press into a single key event, and edits a 4-digit entry buffer
// that is offered to the game logic through a valid/ready handshake.
//
// Ports:
//   clk          100 MHz clock (only clock)
//   rst          synchronous active-high reset
//   key_down     raw, bouncy, asynchronous "any key held" level
//   key_code     hex code of the held key
//   guess_ready  game logic accepts the offered guess
//   guess_valid  a complete 4-digit guess is offered
//   guess        submitted guess, [15:12] is the first digit entered
//   disp_digits  live entry buffer
//   disp_mask    bit i set when nibble i of disp_digits is occupied
//   reject       one-cycle pulse when a debounced key is ignored
module guess_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_down,
  input  logic [3:0]  key_code,
  input  logic        guess_ready,
  output logic        guess_valid,
  output logic [15:0] guess,
  output logic [15:0] disp_digits,
  output logic [3:0]  disp_mask,
  output logic        reject
);

  // The first high sample is taken in RELEASED, so PRESS_PEND counts the
  // remaining DEBOUNCE_CYCLES-1 samples as 0..DEBOUNCE_CYCLES-2.
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } db_state_t;

  typedef enum logic {
    ENTRY  = 1'b0,
    SUBMIT = 1'b1
  } en_state_t;

  // ---------------- synchronizer ----------------
  logic       key_s1, key_s2;
  logic       key_sync;
  logic [1:0] prime;
  logic       armed;

  assign key_sync = key_s2;

  // prime[1] marks the point where key_s2 holds a real sample rather than its
  // reset value. armed stays low until a genuine low is seen, so a key held
  // through reset cannot produce an event until it is released and pressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_s1 <= 1'b0;
      key_s2 <= 1'b0;
      prime  <= 2'b00;
      armed  <= 1'b0;
    end else begin
      key_s1 <= key_down;
      key_s2 <= key_s1;
      prime  <= {prime[0], 1'b1};
      armed  <= armed | (prime[1] & ~key_sync);
    end
  end

  // ---------------- debounce FSM ----------------
  db_state_t     db_state, db_next;
  logic [CW-1:0] db_cnt, cnt_next;
  logic          evt_next;
  logic          key_evt;
  logic [3:0]    key_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      db_state <= RELEASED;
      db_cnt   <= '0;
      key_evt  <= 1'b0;
      key_val  <= 4'h0;
    end else begin
      db_state <= db_next;
      db_cnt   <= cnt_next;
      key_evt  <= evt_next;
      if (evt_next) key_val <= key_code;
    end
  end

  always_comb begin
    db_next  = db_state;
    cnt_next = db_cnt;
    case (db_state)
      RELEASED: begin
        if (key_sync && armed) begin
          db_next  = PRESS_PEND;
          cnt_next = '0;
        end
      end
      PRESS_PEND: begin
        if (!key_sync) begin
          db_next = RELEASED;
        end else if (db_cnt == CNT_LAST) begin
          db_next = PRESSED;
        end else begin
          cnt_next = db_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!key_sync) begin
          db_next  = RELEASE_PEND;
          cnt_next = '0;
        end
      end
      RELEASE_PEND: begin
        if (key_sync) begin
          db_next = PRESSED;
        end else if (db_cnt == CNT_LAST) begin
          db_next = RELEASED;
        end else begin
          cnt_next = db_cnt + 1'b1;
        end
      end
      default: db_next = RELEASED;
    endcase
  end

  // Event fires only on the PRESS_PEND -> PRESSED transition, never while held.
  always_comb begin
    evt_next = (db_state == PRESS_PEND) && key_sync && (db_cnt == CNT_LAST);
  end

  // ---------------- entry FSM ----------------
  en_state_t   en_state, en_next;
  logic [2:0]  count, count_next;
  logic [15:0] buffer, buffer_next;
  logic [15:0] guess_r, guess_next;
  logic        reject_r, reject_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_state <= ENTRY;
      count    <= 3'd0;
      buffer   <= 16'h0000;
      guess_r  <= 16'h0000;
      reject_r <= 1'b0;
    end else begin
      en_state <= en_next;
      count    <= count_next;
      buffer   <= buffer_next;
      guess_r  <= guess_next;
      reject_r <= reject_next;
    end
  end

  always_comb begin
    en_next     = en_state;
    count_next  = count;
    buffer_next = buffer;
    guess_next  = guess_r;
    reject_next = 1'b0;
    case (en_state)
      ENTRY: begin
        if (key_evt) begin
          if (key_val <= 4'd9) begin
            if (count < 3'd4) begin
              buffer_next = {buffer[11:0], key_val};
              count_next  = count + 3'd1;
            end else begin
              reject_next = 1'b1;
            end
          end else if (key_val == 4'hA) begin
            if (count != 3'd0) begin
              buffer_next = {4'h0, buffer[15:4]};
              count_next  = count - 3'd1;
            end else begin
              reject_next = 1'b1;
            end
          end else if (key_val == 4'hB) begin
            buffer_next = 16'h0000;
            count_next  = 3'd0;
          end else if (key_val == 4'hE) begin
            if (count == 3'd4) begin
              guess_next = buffer;
              en_next    = SUBMIT;
            end else begin
              reject_next = 1'b1;
            end
          end else begin
            reject_next = 1'b1;
          end
        end
      end
      SUBMIT: begin
        if (key_evt) reject_next = 1'b1;
        if (guess_ready) begin
          en_next     = ENTRY;
          buffer_next = 16'h0000;
          count_next  = 3'd0;
        end
      end
      default: en_next = ENTRY;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    guess_valid = (en_state == SUBMIT);
    guess       = guess_r;
    disp_digits = buffer;
    reject      = reject_r;
    case (count)
      3'd0:    disp_mask = 4'b0000;
      3'd1:    disp_mask = 4'b0001;
      3'd2:    disp_mask = 4'b0011;
      3'd3:    disp_mask = 4'b0111;
      default: disp_mask = 4'b1111;
    endcase
  end

endmodule

// File: tb/tb_guess_entry_ctrl.sv
// tb/tb_guess_entry_ctrl.sv - self-checking bench for guess_entry_ctrl
module tb_guess_entry_ctrl;

  logic        clk;
  logic        rst;
  logic        key_down;
  logic [3:0]  key_code;
  logic        guess_ready;
  logic        guess_valid;
  logic [15:0] guess;
  logic [15:0] disp_digits;
  logic [3:0]  disp_mask;
  logic        reject;

  guess_entry_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_down    (key_down),
    .key_code    (key_code),
    .guess_ready (guess_ready),
    .guess_valid (guess_valid),
    .guess       (guess),
    .disp_digits (disp_digits),
    .disp_mask   (disp_mask),
    .reject      (reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    int          hold;
    logic        ready;
    logic [15:0] digits;
    logic [3:0]  mask;
    int          rej;
    logic        valid;
    logic [15:0] gs;
  } vec_t;

  vec_t vecs_a[$];
  vec_t vecs_b[$];
  vec_t exp_q[$];

  int tests  = 0;
  int fails  = 0;
  int rej_cnt = 0;

  always @(negedge clk) if (reject) rej_cnt++;

  function automatic vec_t mk(input logic [3:0] code, input int hold, input logic ready,
                              input logic [15:0] digits, input logic [3:0] mask,
                              input int rej, input logic valid, input logic [15:0] gs);
    vec_t v;
    v.code = code; v.hold = hold; v.ready = ready; v.digits = digits;
    v.mask = mask; v.rej = rej; v.valid = valid; v.gs = gs;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One debounced press/release; expectation queued at drive, checked after settle.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    exp_q.push_back(v);
    guess_ready = v.ready;
    key_code    = v.code;
    key_down    = 1'b1;
    rej_cnt     = 0;
    repeat (v.hold) @(negedge clk);
    key_down = 1'b0;
    repeat (14) @(negedge clk);
    guess_ready = 1'b0;
    e = exp_q.pop_front();
    chk($sformatf("vec%0d_digits", idx), {16'h0, disp_digits}, {16'h0, e.digits});
    chk($sformatf("vec%0d_mask", idx), {28'h0, disp_mask}, {28'h0, e.mask});
    chk($sformatf("vec%0d_reject", idx), rej_cnt, e.rej);
    chk($sformatf("vec%0d_valid", idx), {31'h0, guess_valid}, {31'h0, e.valid});
    if (e.valid) chk($sformatf("vec%0d_guess", idx), {16'h0, guess}, {16'h0, e.gs});
  endtask

  initial begin
    rst = 1'b1; key_down = 1'b0; key_code = 4'h0; guess_ready = 1'b0;

    vecs_a.push_back(mk(4'h1,  8, 0, 16'h0001, 4'b0001, 0, 0, 16'h0));
    vecs_a.push_back(mk(4'h2,  8, 0, 16'h0012, 4'b0011, 0, 0, 16'h0));
    vecs_a.push_back(mk(4'h3, 20, 0, 16'h0123, 4'b0111, 0, 0, 16'h0));
    vecs_a.push_back(mk(4'h4,  8, 0, 16'h1234, 4'b1111, 0, 0, 16'h0));
    vecs_a.push_back(mk(4'h5,  8, 0, 16'h1234, 4'b1111, 1, 0, 16'h0));
    vecs_a.push_back(mk(4'hA,  8, 0, 16'h0123, 4'b0111, 0, 0, 16'h0));
    vecs_a.push_back(mk(4'h9,  8, 0, 16'h1239, 4'b1111, 0, 0, 16'h0));
    vecs_a.push_back(mk(4'hB,  8, 0, 16'h0000, 4'b0000, 0, 0, 16'h0));
    vecs_a.push_back(mk(4'hB,  8, 0, 16'h0000, 4'b0000, 0, 0, 16'h0));
    vecs_a.push_back(mk(4'hA,  8, 0, 16'h0000, 4'b0000, 1, 0, 16'h0));
    vecs_a.push_back(mk(4'hC,  8, 0, 16'h0000, 4'b0000, 1, 0, 16'h0));
    vecs_a.push_back(mk(4'hD,  8, 0, 16'h0000, 4'b0000, 1, 0, 16'h0));
    vecs_a.push_back(mk(4'hF,  8, 0, 16'h0000, 4'b0000, 1, 0, 16'h0));
    vecs_a.push_back(mk(4'h4,  8, 1, 16'h0004, 4'b0001, 0, 0, 16'h0));
    vecs_a.push_back(mk(4'h3,  8, 0, 16'h0043, 4'b0011, 0, 0, 16'h0));
    vecs_a.push_back(mk(4'hE,  8, 0, 16'h0043, 4'b0011, 1, 0, 16'h0));
    vecs_a.push_back(mk(4'h2,  8, 0, 16'h0432, 4'b0111, 0, 0, 16'h0));
    vecs_a.push_back(mk(4'h1,  8, 0, 16'h4321, 4'b1111, 0, 0, 16'h0));
    vecs_a.push_back(mk(4'hE,  8, 0, 16'h4321, 4'b1111, 0, 1, 16'h4321));
    vecs_a.push_back(mk(4'h5,  8, 0, 16'h4321, 4'b1111, 1, 1, 16'h4321));

    vecs_b.push_back(mk(4'h8,  8, 0, 16'h0008, 4'b0001, 0, 0, 16'h0));
    vecs_b.push_back(mk(4'h9,  8, 0, 16'h0089, 4'b0011, 0, 0, 16'h0));
    vecs_b.push_back(mk(4'h7,  8, 0, 16'h0897, 4'b0111, 0, 0, 16'h0));
    vecs_b.push_back(mk(4'h6,  8, 0, 16'h8976, 4'b1111, 0, 0, 16'h0));
    vecs_b.push_back(mk(4'hE,  8, 0, 16'h8976, 4'b1111, 0, 1, 16'h8976));

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'h0, guess_valid}, 32'h0);
    chk("rst_guess", {16'h0, guess}, 32'h0);
    chk("rst_digits", {16'h0, disp_digits}, 32'h0);
    chk("rst_mask", {28'h0, disp_mask}, 32'h0);
    chk("rst_reject", {31'h0, reject}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // short bounces never reach a debounced press
    key_code = 4'h7;
    rej_cnt  = 0;
    for (int i = 0; i < 5; i++) begin
      key_down = 1'b1;
      repeat (3) @(negedge clk);
      key_down = 1'b0;
      repeat (4) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    chk("bounce_mask", {28'h0, disp_mask}, 32'h0);
    chk("bounce_digits", {16'h0, disp_digits}, 32'h0);
    chk("bounce_reject", rej_cnt, 0);

    for (int i = 0; i < vecs_a.size(); i++) apply(vecs_a[i], i);

    // handshake after a long wait with ready low
    guess_ready = 1'b1;
    @(negedge clk);
    guess_ready = 1'b0;
    chk("hs_valid", {31'h0, guess_valid}, 32'h0);
    chk("hs_mask", {28'h0, disp_mask}, 32'h0);
    chk("hs_digits", {16'h0, disp_digits}, 32'h0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < vecs_b.size(); i++) apply(vecs_b[i], 100 + i);

    // reset during SUBMIT with a key held through it
    key_code = 4'h8;
    key_down = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_valid", {31'h0, guess_valid}, 32'h0);
    chk("rst2_guess", {16'h0, guess}, 32'h0);
    chk("rst2_digits", {16'h0, disp_digits}, 32'h0);
    chk("rst2_mask", {28'h0, disp_mask}, 32'h0);
    chk("rst2_reject", {31'h0, reject}, 32'h0);
    rst = 1'b0;
    rej_cnt = 0;
    repeat (30) @(negedge clk);
    chk("held_mask", {28'h0, disp_mask}, 32'h0);
    chk("held_digits", {16'h0, disp_digits}, 32'h0);
    chk("held_reject", rej_cnt, 0);
    chk("held_valid", {31'h0, guess_valid}, 32'h0);
    key_down = 1'b0;
    repeat (12) @(negedge clk);
    apply(mk(4'h8, 8, 0, 16'h0008, 4'b0001, 0, 0, 16'h0), 200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
